// File: rtl/edge_pkg.sv
// edge_pkg: shared types and constants for the 3x3 edge window generator.
//   pixel_t - one pixel at the default pixel width
//   win_t   - nine pixels, element 3r+c is window row r, column c
//   state_e - frame control states
package edge_pkg;
  localparam int KernelSize = 3;
  localparam int DefaultMaxImgWidth = 64;
  localparam int DefaultPixelWidth = 8;
  typedef logic [DefaultPixelWidth-1:0] pixel_t;
  typedef pixel_t [KernelSize*KernelSize-1:0] win_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/edge_line_buf.sv
// edge_line_buf: one image row of pixels, asynchronous read and synchronous write at the same index.
//   clk_i   clock
//   we_i    write enable
//   idx_i   column index for both read and write
//   wdata_i pixel written at idx_i
//   rdata_o pixel currently stored at idx_i
module edge_line_buf #(
  parameter int Depth = 64,
  parameter int Width = 8,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] idx_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     rdata_o
);
  logic [Width-1:0] mem_q [Depth];
  assign rdata_o = mem_q[idx_i];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end
endmodule

// File: rtl/edge_window_gen.sv
// edge_window_gen: turns a raster pixel stream into 3x3 windows, one per interior pixel.
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   start_i, cfg_width_i/height_i  frame start pulse and dimensions sampled with it
//   pix_valid_i/pix_ready_o/pix_data_i   upstream pixel handshake
//   win_valid_o/win_ready_i/win_data_o   downstream window handshake
//   win_row_o/win_col_o            centre coordinate of the current window
//   busy_o, done_o, err_o          status; err_o qualifies done_o
module edge_window_gen
  import edge_pkg::*;
#(
  parameter int PixelWidth  = 8,
  parameter int MaxImgWidth = DefaultMaxImgWidth,
  parameter int DimWidth    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DimWidth-1:0]     cfg_width_i,
  input  logic [DimWidth-1:0]     cfg_height_i,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  input  logic [PixelWidth-1:0]   pix_data_i,
  output logic                    win_valid_o,
  input  logic                    win_ready_i,
  output logic [9*PixelWidth-1:0] win_data_o,
  output logic [DimWidth-1:0]     win_row_o,
  output logic [DimWidth-1:0]     win_col_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);
  localparam int AW = $clog2(MaxImgWidth);
  localparam int NW = KernelSize * KernelSize;
  state_e state_q, state_d;
  logic [DimWidth-1:0] w_m1_q, w_m1_d, h_m1_q, h_m1_d;
  logic [DimWidth-1:0] row_q, row_d, col_q, col_d;
  logic [DimWidth-1:0] orow_q, ocol_q;
  logic err_q, err_d, valid_q;
  logic accept, load, last_col, bad;
  logic [PixelWidth-1:0] lb0_rd, lb1_rd;
  // a_q/b_q are the two older window columns, nc the incoming one; index 0 is the top row
  logic [KernelSize-1:0][PixelWidth-1:0] a_q, b_q, nc;
  logic [NW-1:0][PixelWidth-1:0] win_d, win_q;

  assign pix_ready_o = (state_q == RUN) && (!valid_q || win_ready_i);
  assign accept = pix_valid_i && pix_ready_o;
  assign last_col = col_q == w_m1_q;
  // the shift register only holds same-row columns once col>=2, so older columns never leak across a wrap
  assign load = accept && row_q >= DimWidth'(2) && col_q >= DimWidth'(2);
  assign bad = cfg_width_i < DimWidth'(KernelSize) || cfg_height_i < DimWidth'(KernelSize) ||
               cfg_width_i > DimWidth'(MaxImgWidth);
  assign nc = {pix_data_i, lb0_rd, lb1_rd};

  edge_line_buf #(.Depth(MaxImgWidth), .Width(PixelWidth)) lb0 (
    .clk_i(clk_i), .we_i(accept), .idx_i(col_q[AW-1:0]), .wdata_i(pix_data_i), .rdata_o(lb0_rd)
  );
  edge_line_buf #(.Depth(MaxImgWidth), .Width(PixelWidth)) lb1 (
    .clk_i(clk_i), .we_i(accept), .idx_i(col_q[AW-1:0]), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
  );

  always_comb begin
    win_d = '0;
    for (int r = 0; r < KernelSize; r++) begin
      win_d[KernelSize*r]   = a_q[r];
      win_d[KernelSize*r+1] = b_q[r];
      win_d[KernelSize*r+2] = nc[r];
    end
  end

  always_comb begin
    state_d = state_q;
    w_m1_d = w_m1_q;
    h_m1_d = h_m1_q;
    row_d = row_q;
    col_d = col_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        w_m1_d = cfg_width_i - DimWidth'(1);
        h_m1_d = cfg_height_i - DimWidth'(1);
        row_d = '0;
        col_d = '0;
        err_d = bad;
        state_d = bad ? DONE : RUN;
      end
      RUN: if (accept) begin
        col_d = last_col ? '0 : col_q + DimWidth'(1);
        row_d = last_col ? row_q + DimWidth'(1) : row_q;
        state_d = (last_col && row_q == h_m1_q) ? DRAIN : RUN;
      end
      DRAIN: state_d = valid_q ? DRAIN : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      w_m1_q <= '0;
      h_m1_q <= '0;
      row_q <= '0;
      col_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_m1_q <= w_m1_d;
      h_m1_q <= h_m1_d;
      row_q <= row_d;
      col_q <= col_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
      win_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= b_q;
        b_q <= nc;
      end
      if (load) begin
        win_q <= win_d;
        orow_q <= row_q - DimWidth'(1);
        ocol_q <= col_q - DimWidth'(1);
        valid_q <= 1'b1;
      end else if (win_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign win_valid_o = valid_q;
  assign win_data_o = win_q;
  assign win_row_o = orow_q;
  assign win_col_o = ocol_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign err_o = done_o && err_q;
endmodule

// File: tb/tb_edge_window_gen.sv
// tb_edge_window_gen: table-driven frames with a window scoreboard plus multi-cycle corner sequences.
module tb_edge_window_gen;
  localparam int PW = 8;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic win_ready;
  logic [DW-1:0] cfg_w = '0, cfg_h = '0;
  logic [PW-1:0] pix = '0;
  logic pix_ready, win_valid, busy, done, err;
  logic [9*PW-1:0] win_data;
  logic [DW-1:0] win_row, win_col;

  edge_window_gen #(.PixelWidth(PW), .MaxImgWidth(64), .DimWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_width_i(cfg_w), .cfg_height_i(cfg_h),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix),
    .win_valid_o(win_valid), .win_ready_i(win_ready), .win_data_o(win_data),
    .win_row_o(win_row), .win_col_o(win_col), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*PW-1:0] d;
    int r;
    int c;
    int acc;
  } exp_t;
  typedef struct {
    int w;
    int h;
    int kind;
    int base;
    int rmode;
    int poke;
    int err;
  } vec_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int win_cnt = 0, stall_cnt = 0, rdy_mode = 0;
  bit lat_chk = 1'b0;
  logic [9*PW-1:0] first_win, last_win;
  logic [DW-1:0] first_r, first_c, last_r, last_c;
  logic [PW-1:0] img [0:7][0:63];
  int e_first[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int e_last[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int e_rst[9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
  vec_t tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9*PW-1:0] pk(input int e[9]);
    logic [9*PW-1:0] v;
    for (int k = 0; k < 9; k++) v[PW*k +: PW] = PW'(e[k]);
    return v;
  endfunction

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      win_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    logic [9*PW-1:0] hold_d;
    logic [DW-1:0] hold_r, hold_c;
    bit stalled;
    exp_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled && !rst) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, hold_d);
        chk("hold_rc", {win_row, win_col}, {hold_r, hold_c});
      end
      stalled = win_valid && !win_ready;
      hold_d = win_data;
      hold_r = win_row;
      hold_c = win_col;
      if (win_valid && win_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_win actual=row%0d,col%0d required=none", win_row, win_col);
        end else begin
          e = sb.pop_front();
          chk("win_data", win_data, e.d);
          chk("win_rc", {win_row, win_col}, {DW'(e.r), DW'(e.c)});
          if (lat_chk) chk("win_latency", cyc, e.acc + 1);
        end
        if (win_cnt == 0) begin
          first_win = win_data;
          first_r = win_row;
          first_c = win_col;
        end
        last_win = win_data;
        last_r = win_row;
        last_c = win_col;
        win_cnt++;
      end
    end
  end

  task automatic run_frame(input int w, input int h, input int kind, input int base, input int poke,
                           input int exp_err);
    int t;
    bit seen;
    logic [PW-1:0] v;
    exp_t e;
    sb.delete();
    win_cnt = 0;
    stall_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_w = DW'(w);
    cfg_h = DW'(h);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (exp_err != 0) begin
      pix_valid = 1'b1;
      @(negedge clk);
      chk("rej_done", done, 1);
      chk("rej_err", err, 1);
      seen = pix_ready;
      repeat (4) begin
        @(negedge clk);
        seen = seen | pix_ready | done;
      end
      pix_valid = 1'b0;
      chk("rej_no_ready_or_redone", seen, 0);
      chk("rej_wins", win_cnt, 0);
      return;
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        v = kind != 0 ? PW'($urandom_range(0, 255)) : PW'(base + r * w + c);
        img[r][c] = v;
        pix_valid = 1'b1;
        pix = v;
        if (poke != 0 && r * w + c == 10) begin
          start = 1'b1;
          cfg_w = 3;
          cfg_h = 3;
        end
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!pix_ready && t < 500);
        if (!pix_ready) begin
          checks++;
          failures++;
          $display("FAIL pix_accept_timeout actual=waited%0d required=accept", t);
          pix_valid = 1'b0;
          return;
        end
        stall_cnt += t - 1;
        if (r >= 2 && c >= 2) begin
          for (int r2 = 0; r2 < 3; r2++)
            for (int c2 = 0; c2 < 3; c2++) e.d[PW*(3*r2+c2) +: PW] = img[r-2+r2][c-2+c2];
          e.r = r - 1;
          e.c = c - 1;
          e.acc = cyc;
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    pix_valid = 1'b0;
    t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done", done, 1);
    chk("frame_err", err, 0);
    chk("win_count", win_cnt, (w - 2) * (h - 2));
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int t;
    tbl[0] = '{4, 4, 0, 0, 0, 0, 0};
    tbl[1] = '{5, 3, 0, 50, 0, 0, 0};
    tbl[2] = '{2, 8, 0, 0, 0, 0, 1};
    tbl[3] = '{65, 3, 0, 0, 0, 0, 1};
    tbl[4] = '{64, 3, 1, 0, 0, 1, 0};
    tbl[5] = '{6, 5, 1, 0, 1, 0, 0};
    tbl[6] = '{3, 3, 0, 7, 1, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {pix_ready, win_valid, busy, done, err}, 0);
    chk("reset_data", {win_data, win_row, win_col}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {pix_ready, win_valid, busy, done, err}, 0);

    for (int i = 0; i < 7; i++) begin
      rdy_mode = tbl[i].rmode;
      lat_chk = tbl[i].rmode == 0;
      run_frame(tbl[i].w, tbl[i].h, tbl[i].kind, tbl[i].base, tbl[i].poke, tbl[i].err);
      if (i == 0) begin
        chk("first_win_4x4", first_win, pk(e_first));
        chk("first_rc_4x4", {first_r, first_c}, {16'd1, 16'd1});
        chk("last_win_4x4", last_win, pk(e_last));
        chk("last_rc_4x4", {last_r, last_c}, {16'd2, 16'd2});
      end
      if (i == 1) chk("5x3_no_stall", stall_cnt, 0);
    end

    rdy_mode = 2;
    lat_chk = 1'b0;
    @(posedge clk);
    #1;
    fork
      run_frame(4, 4, 0, 20, 0, 0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!win_valid && t < 200);
        chk("bp_first_valid", win_valid, 1);
        chk("bp_ready_drop", pix_ready, 0);
        repeat (6) @(negedge clk);
        chk("bp_still_valid", win_valid, 1);
        chk("bp_ready_low", pix_ready, 0);
        rdy_mode = 0;
      end
    join

    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_w = 4;
    cfg_h = 4;
    @(posedge clk);
    #1;
    start = 1'b0;
    pix_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      pix = PW'(k);
      @(negedge clk);
      chk("rstseq_ready", pix_ready, 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("midrst_outs", {pix_ready, win_valid, busy, done, err}, 0);
    chk("midrst_data", {win_data, win_row, win_col}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_chk = 1'b1;
    run_frame(4, 4, 0, 100, 0, 0);
    chk("after_rst_first_win", first_win, pk(e_rst));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
